uart_frame_rx: RTL and testbench

Receives the serial stream from the team's 5-byte UART frame transmitter and reassembles the 40-bit word. It is the downstream stage of that transmitter: 8N1 bytes arrive LSB-first, and bytes 0..4 map to bits [7:0]..[39:32]. The block oversamples `uart_rx` on `sys_clk`, recovers each byte, and groups bytes into frames. An inter-byte timeout resynchronises frame alignment. It presents the word with a one-cycle valid strobe.

---
 rtl/uart_frame_rx.sv | 144 ++++++++++++++
 tb/tb_uart_frame_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | uart_frame_rx : 8N1 receiver that reassembles 5-byte (40-bit) frames   |
// | Revision      : 1.0                                                    |
// +------------------------------------------------------------------------+
module uart_frame_rx #(
   parameter int BAUD_DIV     = 5208,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        uart_rx,
   output logic [7:0]  rx_byte,
   output logic        byte_valid,
   output logic [39:0] Data,
   output logic        frame_valid,
   output logic        frame_err
);
   localparam int CNT_W    = $clog2(BAUD_DIV);
   localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(BAUD_DIV - 1);
   localparam logic [TO_W-1:0]  C_TO_LAST   = TO_W'(TO_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              sync1_q, rxs_q, rxs_prev_q;
   logic [7:0]        rx_byte_q;
   logic              byte_valid_q, frame_err_q, frame_valid_q;
   logic [2:0]        byte_idx_q;
   logic [31:0]       shadow_q;
   logic [39:0]       data_q;
   logic [TO_W-1:0]   idle_q;
   logic              byte_done, stop_err, start_det, timeout;

   assign timeout = (idle_q == C_TO_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      stop_err  = 1'b0;
      start_det = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (rxs_prev_q && !rxs_q) begin
               start_det = 1'b1;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (cnt_q == C_HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rxs_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == C_BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rxs_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            // Leaving at mid-stop lets a back-to-back start edge be seen in IDLE.
            if (cnt_q == C_BIT_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
               if (rxs_q) byte_done = 1'b1;
               else       stop_err  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         sync1_q       <= 1'b1;
         rxs_q         <= 1'b1;
         rxs_prev_q    <= 1'b1;
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rx_byte_q     <= '0;
         byte_valid_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         frame_valid_q <= 1'b0;
         byte_idx_q    <= '0;
         shadow_q      <= '0;
         data_q        <= '0;
         idle_q        <= '0;
      end else begin
         sync1_q       <= uart_rx;
         rxs_q         <= sync1_q;
         rxs_prev_q    <= rxs_q;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         byte_valid_q  <= byte_done;
         frame_err_q   <= stop_err;
         frame_valid_q <= 1'b0;
         if (byte_done) rx_byte_q <= shift_q;

         if (state_q != S_IDLE || byte_idx_q == 3'd0 || start_det || timeout)
            idle_q <= '0;
         else
            idle_q <= idle_q + TO_W'(1);

         // Errors and timeouts realign so the next good byte is byte 0.
         if (stop_err || timeout) begin
            byte_idx_q <= '0;
         end else if (byte_valid_q) begin
            if (byte_idx_q == 3'd4) begin
               data_q        <= {rx_byte_q, shadow_q};
               frame_valid_q <= 1'b1;
               byte_idx_q    <= '0;
            end else begin
               shadow_q[{byte_idx_q[1:0], 3'b000} +: 8] <= rx_byte_q;
               byte_idx_q <= byte_idx_q + 3'd1;
            end
         end
      end
   end

   assign rx_byte     = rx_byte_q;
   assign byte_valid  = byte_valid_q;
   assign Data        = data_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_uart_frame_rx : randomized frame stimulus vs. behavioural model     |
// | Revision         : 1.0                                                 |
// +------------------------------------------------------------------------+
module tb_uart_frame_rx;
   localparam int BD   = 16;
   localparam int TB   = 20;
   localparam int HALF = BD / 2;
   localparam int LAT  = HALF + 9 * BD + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        uart_rx = 1'b1;
   logic [7:0]  rx_byte;
   logic        byte_valid, frame_valid, frame_err;
   logic [39:0] Data;

   uart_frame_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TB)) dut (
      .sys_clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_byte(rx_byte),
      .byte_valid(byte_valid), .Data(Data), .frame_valid(frame_valid),
      .frame_err(frame_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  val;
      bit          is_err;
      bit          last;
      logic [39:0] frame;
      int          start;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0, failures = 0, cycle = 0;
   logic [7:0]  part[5];
   int          part_n = 0, idle_acc = 0;
   logic [39:0] exp_data = '0, pend_word = '0;
   logic [7:0]  exp_rx = '0;
   bit          pend_f = 1'b0;
   int          frames_seen = 0, last_fcyc = 0, prev_fcyc = 0;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic chk_win(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cycle);
      end
   endtask

   always @(posedge clk) cycle <= cycle + 1;

   always @(posedge clk) begin : cmp
      ev_t ev;
      #1;
      if (rst) begin
         exp_data = '0;
         exp_rx   = '0;
         pend_f   = 1'b0;
      end else begin
         if (pend_f) begin
            chk("frame_valid_after_5th_byte", frame_valid, 1);
            chk("Data_on_frame", Data, pend_word);
            exp_data = pend_word;
            frames_seen++;
            prev_fcyc = last_fcyc;
            last_fcyc = cycle;
         end else begin
            chk("frame_valid_quiet", frame_valid, 0);
            chk("Data_hold", Data, exp_data);
         end
         pend_f = 1'b0;
         chk("strobes_exclusive", byte_valid & frame_err, 0);
         if (byte_valid || frame_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", {byte_valid, frame_err}, 0);
            end else begin
               ev = exp_q.pop_front();
               chk("strobe_kind", {byte_valid, frame_err}, ev.is_err ? 2'b01 : 2'b10);
               chk_win("strobe_latency", cycle - ev.start, LAT - 1, LAT + 1);
               if (!ev.is_err) begin
                  chk("rx_byte", rx_byte, ev.val);
                  exp_rx = ev.val;
                  if (ev.last) begin
                     pend_f    = 1'b1;
                     pend_word = ev.frame;
                  end
               end
            end
         end else begin
            chk("rx_byte_hold", rx_byte, exp_rx);
         end
      end
   end

   task automatic bit_out(input logic b);
      uart_rx = b;
      repeat (BD) @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bit_out(1'b1);
      idle_acc += n;
   endtask

   // Model: timeout drops a partial frame; a bad stop bit drops it too.
   task automatic send(input logic [7:0] v, input bit stop_ok);
      ev_t e;
      if (idle_acc >= TB) part_n = 0;
      idle_acc = 0;
      e.val = v; e.is_err = !stop_ok; e.last = 1'b0; e.frame = '0; e.start = cycle;
      if (stop_ok) begin
         part[part_n] = v;
         part_n++;
         if (part_n == 5) begin
            e.last = 1'b1;
            for (int i = 0; i < 5; i++) e.frame[8*i +: 8] = part[i];
            part_n = 0;
         end
      end else begin
         part_n = 0;
      end
      exp_q.push_back(e);
      bit_out(1'b0);
      for (int i = 0; i < 8; i++) bit_out(v[i]);
      bit_out(stop_ok);
      if (!stop_ok) begin
         bit_out(1'b1);
         idle_acc = 1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] rv;
      int         n0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_rx_byte", rx_byte, 0);
      chk("reset_byte_valid", byte_valid, 0);
      chk("reset_Data", Data, 0);
      chk("reset_frame_valid", frame_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      rst = 1'b0;
      idle(2);

      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      idle(2);
      chk("single_frame_Data", Data, 40'h05_0403_0201);

      // Short low glitch on an idle line must be rejected.
      uart_rx = 1'b0;
      repeat (BD / 4) @(posedge clk);
      #2;
      idle_acc = 0;
      idle(3);

      send(8'hA5, 1'b0);
      for (int i = 1; i <= 5; i++) send(8'(8'h11 * i), 1'b1);
      idle(2);
      chk("after_stop_err_Data", Data, 40'h55_4433_2211);

      n0 = frames_seen;
      send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b1);
      idle(25);
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      idle(2);
      chk("timeout_frame_count", frames_seen - n0, 1);
      chk("timeout_Data", Data, 40'h05_0403_0201);

      // Reset during bit 4 of byte 3C, line released high with reset.
      rv = 8'h3C;
      bit_out(1'b0);
      for (int i = 0; i < 4; i++) bit_out(rv[i]);
      uart_rx = rv[4];
      repeat (HALF) @(posedge clk);
      #2;
      rst = 1'b1; uart_rx = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      chk("midreset_rx_byte", rx_byte, 0);
      chk("midreset_Data", Data, 0);
      chk("midreset_strobes", {byte_valid, frame_valid, frame_err}, 0);
      part_n = 0; idle_acc = 0;
      idle(4);
      send(8'hDE, 1'b1); send(8'hAD, 1'b1); send(8'hBE, 1'b1);
      send(8'hEF, 1'b1); send(8'h42, 1'b1);
      idle(2);
      chk("post_reset_Data", Data, 40'h42_EFBE_ADDE);

      for (int i = 0; i < 10; i++) send(8'(i * 7 + 3), 1'b1);
      idle(2);
      chk("frame_spacing", last_fcyc - prev_fcyc, 50 * BD);

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 7) == 0) idle($urandom_range(22, 26));
         else                           idle($urandom_range(0, 3));
         send(8'($urandom), $urandom_range(0, 7) != 0);
      end
      idle(4);
      chk("events_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
